// File: rtl/sram_pkg.sv
// Shared types and widths for the off-chip SRAM arbiter.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int WORD_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_t;

endpackage

// File: rtl/sram_grant_sel.sv
// Fetch/data priority selection with a bounded data streak so fetch cannot starve.
module sram_grant_sel #(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

  localparam int SW = (DATA_STREAK_MAX < 1) ? 1 : $clog2(DATA_STREAK_MAX + 1);

  logic [SW-1:0] streak;
  logic          fetch_turn;

  // Data normally wins; fetch wins when alone or once the data streak is exhausted.
  always_comb begin
    fetch_turn = if_req && (!d_req || (streak == SW'(DATA_STREAK_MAX)));
    grant_if   = idle && fetch_turn;
    grant_d    = idle && d_req && !fetch_turn;
  end

  // Streak counts data grants made while fetch waits; cleared by a fetch grant or idle fetch port.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!if_req || grant_if) begin
      streak <= '0;
    end else if (grant_d) begin
      streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-SRAM arbiter between instruction fetch and data ports; all SRAM pins registered.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int RD_WAIT         = 1,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [15:0]            if_addr,
  output logic                   if_ack,
  output logic [WORD_W-1:0]      if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [1:0]             d_be,
  input  logic [15:0]            d_addr,
  input  logic [WORD_W-1:0]      d_wdata,
  output logic                   d_ack,
  output logic [WORD_W-1:0]      d_rdata,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  logic [WORD_W-1:0]      SRAM_DQ,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  // Read holds OE low for RD_WAIT+2 cycles; counter loads RD_WAIT+1 and samples at zero.
  localparam int CW = $clog2(RD_WAIT + 2);

  state_t                 state, state_n;
  port_t                  port, port_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [SRAM_ADDR_W-1:0] addr_n;
  logic                   ce_n_n, oe_n_n, we_n_n, ub_n_n, lb_n_n;
  logic                   dq_oe, dq_oe_n;
  logic [WORD_W-1:0]      dq_out, dq_out_n;
  logic [WORD_W-1:0]      if_rdata_n, d_rdata_n;
  logic                   if_ack_n, d_ack_n;
  logic                   grant_if, grant_d;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = if_addr[0] ^ d_addr[0];

  sram_grant_sel #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_grant_sel (
    .clk      (clk),
    .rst      (rst),
    .idle     (state == IDLE),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign SRAM_DQ = dq_oe ? dq_out : 'z;

  // Next-state and next registered pin values; pins hold unless a state changes them.
  always_comb begin
    state_n    = state;
    port_n     = port;
    cnt_n      = cnt;
    addr_n     = SRAM_ADDR;
    ce_n_n     = SRAM_CE_N;
    oe_n_n     = SRAM_OE_N;
    we_n_n     = 1'b1;
    ub_n_n     = SRAM_UB_N;
    lb_n_n     = SRAM_LB_N;
    dq_oe_n    = dq_oe;
    dq_out_n   = dq_out;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    if_ack_n   = 1'b0;
    d_ack_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          port_n = PORT_D;
          addr_n = SRAM_ADDR_W'(d_addr[15:1]);
          ce_n_n = 1'b0;
          if (d_we) begin
            ub_n_n   = ~d_be[1];
            lb_n_n   = ~d_be[0];
            dq_oe_n  = 1'b1;
            dq_out_n = d_wdata;
            state_n  = WR_SETUP;
          end else begin
            ub_n_n  = 1'b0;
            lb_n_n  = 1'b0;
            oe_n_n  = 1'b0;
            cnt_n   = CW'(RD_WAIT + 1);
            state_n = RD;
          end
        end else if (grant_if) begin
          port_n  = PORT_IF;
          addr_n  = SRAM_ADDR_W'(if_addr[15:1]);
          ce_n_n  = 1'b0;
          ub_n_n  = 1'b0;
          lb_n_n  = 1'b0;
          oe_n_n  = 1'b0;
          cnt_n   = CW'(RD_WAIT + 1);
          state_n = RD;
        end
      end
      RD: begin
        if (cnt == '0) begin
          if (port == PORT_IF) begin
            if_rdata_n = SRAM_DQ;
            if_ack_n   = 1'b1;
          end else begin
            d_rdata_n = SRAM_DQ;
            d_ack_n   = 1'b1;
          end
          ce_n_n  = 1'b1;
          oe_n_n  = 1'b1;
          ub_n_n  = 1'b1;
          lb_n_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WR_SETUP: begin
        we_n_n  = 1'b0;
        state_n = WR_PULSE;
      end
      WR_PULSE: begin
        state_n = WR_HOLD;
      end
      WR_HOLD: begin
        d_ack_n = 1'b1;
        ce_n_n  = 1'b1;
        ub_n_n  = 1'b1;
        lb_n_n  = 1'b1;
        dq_oe_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and every SRAM-facing/ack/read-data register; reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      port      <= PORT_IF;
      cnt       <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      state     <= state_n;
      port      <= port_n;
      cnt       <= cnt_n;
      SRAM_ADDR <= addr_n;
      SRAM_CE_N <= ce_n_n;
      SRAM_OE_N <= oe_n_n;
      SRAM_WE_N <= we_n_n;
      SRAM_UB_N <= ub_n_n;
      SRAM_LB_N <= lb_n_n;
      dq_oe     <= dq_oe_n;
      dq_out    <= dq_out_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      if_ack    <= if_ack_n;
      d_ack     <= d_ack_n;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM and word-memory reference.
module tb_sram_arbiter;

  localparam int RD_WAIT = 1;
  localparam int STREAK  = 4;
  localparam int RD_LAT  = 2 + RD_WAIT;
  localparam int WR_LAT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_be;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] sram_dq;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int n_checks = 0;
  int n_fail   = 0;
  int clash_cnt = 0;

  logic [15:0] sram_mem [0:32767];
  logic [15:0] ref_mem  [0:32767];

  sram_arbiter #(
    .RD_WAIT         (RD_WAIT),
    .DATA_STREAK_MAX (STREAK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (sram_dq),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives the bus on a read, captures enabled lanes while WE is low.
  assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR[14:0]] : 'z;

  always @(negedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_LB_N) sram_mem[SRAM_ADDR[14:0]][7:0]  <= sram_dq[7:0];
      if (!SRAM_UB_N) sram_mem[SRAM_ADDR[14:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge clk) begin
    if (dut.dq_oe && !SRAM_OE_N) clash_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_read(input logic [15:0] byte_addr);
    return ref_mem[int'(byte_addr) / 2];
  endfunction

  task automatic ref_write(input logic [15:0] byte_addr, input logic [15:0] data, input logic [1:0] be);
    int w;
    logic [15:0] old;
    w   = int'(byte_addr) / 2;
    old = ref_mem[w];
    ref_mem[w] = {be[1] ? data[15:8] : old[15:8], be[0] ? data[7:0] : old[7:0]};
  endtask

  // One transaction on one port; reports ack latency (cycles after the grant edge) and pin observations.
  task automatic run_txn(input bit is_d, input bit we, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rdata, output int we_low,
                         output logic [19:0] addr_seen, output logic [1:0] ubl_seen);
    lat = -1; rdata = '0; we_low = 0; addr_seen = '0; ubl_seen = 2'b11;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!SRAM_CE_N) begin
        addr_seen = SRAM_ADDR;
        ubl_seen  = {SRAM_UB_N, SRAM_LB_N};
      end
      if (!SRAM_WE_N) we_low++;
      if (is_d ? d_ack : if_ack) begin
        lat   = i;
        rdata = is_d ? d_rdata : if_rdata;
        break;
      end
    end
    if (is_d) d_req = 1'b0;
    else      if_req = 1'b0;
  endtask

  task automatic new_d_op();
    d_we    = 1'($urandom_range(0, 1));
    d_be    = 2'($urandom_range(0, 3));
    d_addr  = 16'(16'h0100 + $urandom_range(0, 63));
    d_wdata = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
    end
    n_checks++;
    if (SRAM_ADDR !== 20'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000", SRAM_ADDR); end
    n_checks++;
    if ({if_ack, d_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", {if_ack, d_ack}); end
    n_checks++;
    if ({if_rdata, d_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata}); end
    n_checks++;
    if (dut.dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq: driver on %b expected 0", dut.dq_oe); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({if_ack, d_ack, SRAM_CE_N} !== 3'b001) begin
        n_fail++;
        $display("FAIL idle_quiet: acks/ce_n %b expected 001", {if_ack, d_ack, SRAM_CE_N});
      end
    end
  endtask

  task automatic test_write_read();
    int lat, we_low;
    logic [15:0] rd;
    logic [19:0] a;
    logic [1:0] ubl;
    run_txn(1'b1, 1'b1, 2'b11, 16'h0100, 16'hBEEF, lat, rd, we_low, a, ubl);
    ref_write(16'h0100, 16'hBEEF, 2'b11);
    n_checks++;
    if (lat != WR_LAT) begin n_fail++; $display("FAIL wr_lat: got %0d expected %0d", lat, WR_LAT); end
    n_checks++;
    if (we_low != 1) begin n_fail++; $display("FAIL wr_we_pulse: got %0d expected 1", we_low); end
    n_checks++;
    if (a !== 20'h00080) begin n_fail++; $display("FAIL wr_addr: got %h expected 00080", a); end
    n_checks++;
    if (ubl !== 2'b00) begin n_fail++; $display("FAIL wr_lanes: got %b expected 00", ubl); end
    run_txn(1'b0, 1'b0, 2'b00, 16'h0100, 16'h0, lat, rd, we_low, a, ubl);
    n_checks++;
    if (lat != RD_LAT) begin n_fail++; $display("FAIL if_lat: got %0d expected %0d", lat, RD_LAT); end
    n_checks++;
    if (rd !== ref_read(16'h0100)) begin n_fail++; $display("FAIL if_data: got %h expected %h", rd, ref_read(16'h0100)); end
  endtask

  task automatic test_byte_write();
    int lat, we_low;
    logic [15:0] rd;
    logic [19:0] a;
    logic [1:0] ubl;
    run_txn(1'b1, 1'b1, 2'b01, 16'h0100, 16'h12AB, lat, rd, we_low, a, ubl);
    ref_write(16'h0100, 16'h12AB, 2'b01);
    n_checks++;
    if (ubl !== 2'b10) begin n_fail++; $display("FAIL bw_lanes: got %b expected 10", ubl); end
    n_checks++;
    if (lat != WR_LAT || we_low != 1) begin
      n_fail++; $display("FAIL bw_timing: lat %0d we_low %0d expected %0d 1", lat, we_low, WR_LAT);
    end
    run_txn(1'b1, 1'b0, 2'b00, 16'h0100, 16'h0, lat, rd, we_low, a, ubl);
    n_checks++;
    if (rd !== ref_read(16'h0100)) begin n_fail++; $display("FAIL bw_readback: got %h expected %h", rd, ref_read(16'h0100)); end
    n_checks++;
    if (ubl !== 2'b00 || lat != RD_LAT) begin
      n_fail++; $display("FAIL d_read: lanes %b lat %0d expected 00 %0d", ubl, lat, RD_LAT);
    end
  endtask

  task automatic test_odd_addr();
    int lat, we_low;
    logic [15:0] rd;
    logic [19:0] a;
    logic [1:0] ubl;
    run_txn(1'b0, 1'b0, 2'b00, 16'h0101, 16'h0, lat, rd, we_low, a, ubl);
    n_checks++;
    if (a !== 20'h00080) begin n_fail++; $display("FAIL odd_addr: got %h expected 00080", a); end
    n_checks++;
    if (rd !== ref_read(16'h0101)) begin n_fail++; $display("FAIL odd_data: got %h expected %h", rd, ref_read(16'h0101)); end
    run_txn(1'b1, 1'b1, 2'b00, 16'h0101, 16'h5555, lat, rd, we_low, a, ubl);
    ref_write(16'h0101, 16'h5555, 2'b00);
    n_checks++;
    if (lat != WR_LAT || ubl !== 2'b11) begin
      n_fail++; $display("FAIL be00_write: lat %0d lanes %b expected %0d 11", lat, ubl, WR_LAT);
    end
    run_txn(1'b1, 1'b0, 2'b11, 16'h0100, 16'h0, lat, rd, we_low, a, ubl);
    n_checks++;
    if (rd !== ref_read(16'h0100)) begin n_fail++; $display("FAIL be00_unchanged: got %h expected %h", rd, ref_read(16'h0100)); end
  endtask

  task automatic test_simultaneous();
    int lat, we_low, d_at, i_at;
    logic [15:0] rd, d_data, i_data;
    logic [19:0] a;
    logic [1:0] ubl;
    run_txn(1'b1, 1'b1, 2'b11, 16'h0200, 16'hA1B2, lat, rd, we_low, a, ubl);
    ref_write(16'h0200, 16'hA1B2, 2'b11);
    run_txn(1'b1, 1'b1, 2'b11, 16'h0300, 16'hC3D4, lat, rd, we_low, a, ubl);
    ref_write(16'h0300, 16'hC3D4, 2'b11);
    d_at = -1; i_at = -1; d_data = '0; i_data = '0;
    d_req = 1'b1; d_we = 1'b0; d_be = 2'b11; d_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0300;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_ack && d_at < 0) begin d_at = i; d_data = d_rdata; d_req = 1'b0; end
      if (if_ack) begin i_at = i; i_data = if_rdata; if_req = 1'b0; break; end
    end
    d_req = 1'b0; if_req = 1'b0;
    n_checks++;
    if (d_at != RD_LAT) begin n_fail++; $display("FAIL sim_d_first: d_ack at %0d expected %0d", d_at, RD_LAT); end
    n_checks++;
    if (i_at != 2 * RD_LAT + 1) begin n_fail++; $display("FAIL sim_if_next: if_ack at %0d expected %0d", i_at, 2 * RD_LAT + 1); end
    n_checks++;
    if (d_data !== ref_read(16'h0200) || i_data !== ref_read(16'h0300)) begin
      n_fail++; $display("FAIL sim_data: got %h %h expected %h %h", d_data, i_data, ref_read(16'h0200), ref_read(16'h0300));
    end
  endtask

  task automatic test_streak();
    int kinds[$];
    int acks;
    acks = 0;
    new_d_op();
    d_req = 1'b1;
    if_addr = 16'(16'h0100 + $urandom_range(0, 63));
    if_req = 1'b1;
    for (int i = 0; i < 600 && acks < 20; i++) begin
      @(negedge clk);
      if (d_ack) begin
        kinds.push_back(1);
        acks++;
        if (d_we) begin
          ref_write(d_addr, d_wdata, d_be);
        end else begin
          n_checks++;
          if (d_rdata !== ref_read(d_addr)) begin
            n_fail++; $display("FAIL rnd_d_read @%h: got %h expected %h", d_addr, d_rdata, ref_read(d_addr));
          end
        end
        new_d_op();
      end
      if (if_ack) begin
        kinds.push_back(0);
        acks++;
        n_checks++;
        if (if_rdata !== ref_read(if_addr)) begin
          n_fail++; $display("FAIL rnd_if_read @%h: got %h expected %h", if_addr, if_rdata, ref_read(if_addr));
        end
        if_addr = 16'(16'h0100 + $urandom_range(0, 63));
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (acks != 20) begin n_fail++; $display("FAIL streak_count: got %0d acks expected 20", acks); end
    foreach (kinds[k]) begin
      n_checks++;
      if (kinds[k] != ((k % (STREAK + 1) == STREAK) ? 0 : 1)) begin
        n_fail++; $display("FAIL streak_order[%0d]: got port %0d expected %0d", k, kinds[k], (k % (STREAK + 1) == STREAK) ? 0 : 1);
      end
    end
    n_checks++;
    if (clash_cnt != 0) begin n_fail++; $display("FAIL dq_contention: got %0d cycles expected 0", clash_cnt); end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    found = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 2'b11; d_addr = 16'h0400; d_wdata = 16'hCAFE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!SRAM_WE_N) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_mid_pulse: WE_N low seen %0d expected 1", found); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({SRAM_WE_N, SRAM_CE_N, dut.dq_oe, d_ack} !== 4'b1100) begin
      n_fail++; $display("FAIL rst_mid_state: we_n/ce_n/dq_oe/ack %b expected 1100", {SRAM_WE_N, SRAM_CE_N, dut.dq_oe, d_ack});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noack: got %b expected 0", d_ack); end
    end
    d_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_after_noack: got %b expected 0", d_ack); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    test_reset();
    test_write_read();
    test_byte_write();
    test_odd_addr();
    test_simultaneous();
    test_streak();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
